if_prefetch: RTL
================

IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of prefetch-queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-003 SHALL have port clk input 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst input 1, reset; synchronous and active-high.
REQ-005 SHALL have port imem_req output 1, instruction-memory read request.
REQ-006 SHALL have port imem_addr output 16, word address of the request.
REQ-007 SHALL have port imem_ack input 1, read complete; imem_rdata is valid in the same cycle.
REQ-008 SHALL have port imem_rdata input 16, fetched instruction word.
REQ-009 SHALL have port branch_taken input 1, one-cycle redirect pulse from execute.
REQ-010 SHALL have port branch_target input 16, redirect address, sampled when branch_taken=1.
REQ-011 SHALL have port stall input 1, decode not ready; blocks dequeue.
REQ-012 SHALL have port instr output 16, head-of-queue instruction to decode.
REQ-013 SHALL have port instr_pc output 16, address of instr.
REQ-014 SHALL have port instr_valid output 1, queue non-empty.

Function
REQ-015 SHALL use word addressing: next fetch PC = fetch_pc + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-016 SHALL implement FSM states IDLE, REQ, DISCARD.
REQ-017 IDLE->REQ SHALL occur when (queue count + outstanding) < DEPTH; imem_req=1, imem_addr=fetch_pc, held stable until imem_ack.
REQ-018 In REQ on imem_ack without redirect: push {fetch_pc, imem_rdata}, fetch_pc+=1, ->IDLE (back-to-back REQ permitted next cycle if space).
REQ-019 In REQ on branch_taken without imem_ack: ->DISCARD; imem_req stays 1 with old address until ack.
REQ-020 In DISCARD on imem_ack: drop data, ->IDLE; no push.
REQ-021 branch_taken SHALL flush the queue in the same edge, load fetch_pc=branch_target, and take priority over push and pop.
REQ-022 branch_taken coincident with imem_ack in REQ: ack data dropped, ->IDLE, next request uses branch_target.
REQ-023 branch_taken during DISCARD: fetch_pc updates to the newest target; remain DISCARD.
REQ-024 instr_valid=1 iff queue non-empty; instr/instr_pc show head entry combinationally from storage.
REQ-025 Pop SHALL occur when instr_valid=1 and stall=0 and branch_taken=0.
REQ-026 Simultaneous push and pop on a full queue SHALL be legal; count unchanged.
REQ-027 Latency: imem_ack at cycle N with empty queue -> instr_valid=1 at N+1.
REQ-028 Queue SHALL never overflow: the REQ-017 credit check includes the outstanding request.

Reset
REQ-029 While rst=1: state=IDLE, fetch_pc=RESET_PC, queue empty, imem_req=0, instr_valid=0, instr=0, instr_pc=0, imem_addr=0.
REQ-030 First request SHALL assert the cycle after rst deasserts, addr=RESET_PC.
REQ-031 rst mid-request SHALL abandon it; a late imem_ack after reset SHALL be ignored unless a new request is pending.

Structure
REQ-032 FSM state encoding and the 16-bit word width constant SHALL live in the shared package used by the core.
REQ-033 The queue SHALL be one sub-module, if_fifo (parameterised DEPTH, data width 32, push/pop/flush, count).

Verification
REQ-034 Reset, memory acks every cycle with rdata=addr^16'hA5A5, stall=0 -> instr_pc sequence 0,1,2,... one per cycle after fill, instr matches.
REQ-035 stall=1 for 10 cycles -> exactly DEPTH entries held, imem_req drops, no loss; on release PCs continue in order.
REQ-036 branch_taken with target 16'h0040 while request to 16'h0003 is waiting 3 cycles for ack -> 16'h0003 data never appears; next instr_pc=16'h0040.
REQ-037 branch_taken coincident with imem_ack -> acked word dropped, queue empty next cycle, next imem_addr=branch_target.
REQ-038 RESET_PC=16'hFFFE, no stall -> instr_pc 16'hFFFE, 16'hFFFF, 16'h0000.
REQ-039 rst asserted with a pending request and two queued entries -> all outputs zero next cycle, restart from RESET_PC.

Source files
------------

// File: rtl/if_prefetch_pkg.sv
// Shared definitions for the instruction-fetch prefetch block.
//   WORD_W  : instruction / address word width
//   state_e : fetch FSM state encoding
//   qent_t  : one prefetch-queue entry {pc, instruction}
package if_prefetch_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } qent_t;

  // Word-addressed PC increment; wraps naturally at 2^WORD_W.
  function automatic logic [WORD_W-1:0] pc_inc(input logic [WORD_W-1:0] pc);
    return pc + WORD_W'(1);
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Prefetch queue: circular buffer with push/pop/flush and occupancy count.
//   clk, rst      : clock, synchronous active-high reset
//   i_push/i_data : enqueue (accepted when not full, or full with a pop)
//   i_pop         : dequeue head (ignored when empty)
//   i_flush       : empty the queue; overrides push and pop
//   o_data        : head entry, read straight from storage
//   o_count       : number of valid entries
//   o_empty       : queue empty
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [W-1:0]               i_data,
  output logic [W-1:0]               o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic          w_full, w_push_ok, w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop_ok  = i_pop & ~o_empty;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign w_push_ok = i_push & (~w_full | w_pop_ok);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop_ok)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
    end
  end

  // Storage is not reset; readers qualify with o_empty.
  always_ff @(posedge clk) begin
    if (w_push_ok && !i_flush && !rst) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: issues word reads ahead of decode into a small
// queue, handles branch redirects (flush + discard of in-flight reads).
//   clk, rst                 : clock, synchronous active-high reset
//   imem_req/imem_addr       : memory read request, held until imem_ack
//   imem_ack/imem_rdata      : read completion with data in the same cycle
//   branch_taken/_target     : one-cycle redirect from execute
//   stall                    : decode not ready, blocks dequeue
//   instr/instr_pc/instr_valid : queue head to decode
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_target,
  input  logic              stall,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  output logic              instr_valid
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e            r_state, w_state_nxt;
  logic [WORD_W-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [WORD_W-1:0] r_req_addr;
  logic              w_push, w_pop, w_empty, w_space;
  logic [CW-1:0]     w_count, w_count_nxt;
  qent_t             w_push_ent, w_head;

  if_fifo #(.DEPTH(DEPTH), .W(2*WORD_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (branch_taken),
    .i_data  (w_push_ent),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign w_push_ent = '{pc: r_fetch_pc, instr: imem_rdata};
  assign w_pop      = instr_valid & ~stall & ~branch_taken;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_push         = 1'b0;

    if (r_state == ST_REQ && imem_ack && !branch_taken) begin
      w_push         = 1'b1;
      w_fetch_pc_nxt = pc_inc(r_fetch_pc);
    end
    if (branch_taken) w_fetch_pc_nxt = branch_target;

    // Credit check on post-edge occupancy with no read outstanding: a new
    // request is only issued when its data is guaranteed a slot.
    w_count_nxt = branch_taken ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
    w_space     = (w_count_nxt < CW'(DEPTH));

    unique case (r_state)
      ST_IDLE: if (w_space) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (imem_ack)          w_state_nxt = (!branch_taken && w_space) ? ST_REQ : ST_IDLE;
        else if (branch_taken) w_state_nxt = ST_DISCARD;
      end
      ST_DISCARD: if (imem_ack) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      // Latched only when a request (re)starts, so the address of a read
      // being discarded stays put while fetch_pc already points at the target.
      if (w_state_nxt == ST_REQ) r_req_addr <= w_fetch_pc_nxt;
    end
  end

  // Outputs are forced quiet during reset, before the state has been cleared.
  assign imem_req    = ~rst & (r_state != ST_IDLE);
  assign imem_addr   = imem_req ? r_req_addr : '0;
  assign instr_valid = ~rst & ~w_empty;
  assign instr       = instr_valid ? w_head.instr : '0;
  assign instr_pc    = instr_valid ? w_head.pc    : '0;

endmodule
